btn_step_conditioner: RTL

- Conditions the two raw PWM push-buttons (increment, decrement) before they reach the PWM duty-cycle stage.
- Per button: 2-flop synchronise, counter-debounce, emit single-cycle step pulses.
- Also provides debounced "held" levels for the inled/deled indicator LEDs.
- Sits directly upstream of the pwm block; its pulses replace raw btn_incrPWM/btn_decrPWM.

---
 rtl/btn_step_conditioner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/btn_step_conditioner.sv
// Synchronises, debounces and edge-detects the two PWM step buttons; also outputs the held levels.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while a single button stays held.
module btn_step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_incr,
  input  logic btn_decr,
  output logic incr_pulse,
  output logic decr_pulse,
  output logic incr_held,
  output logic decr_held
);

  localparam int unsigned NCH      = 2;
  localparam int unsigned MAX_DR   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_TERM = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } ch_state_e;

  // Channel 0 is increment, channel 1 is decrement.
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [NCH-1:0]   stable_q, stable_d;
  logic [NCH-1:0]   pulse_q, pulse_d;
  logic [NCH-1:0]   other_held;
  ch_state_e        state_q [NCH];
  ch_state_e        state_d [NCH];
  logic [CNT_W-1:0] db_cnt_q [NCH];
  logic [CNT_W-1:0] db_cnt_d [NCH];
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt_q [NCH];
  logic [CNT_W-1:0] rpt_cnt_d [NCH];
`endif

  assign raw        = {btn_decr, btn_incr};
  assign other_held = {stable_q[0], stable_q[1]};

  // State register: synchronisers, debounce, per-channel FSM and pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        db_cnt_q[i] <= '0;
`ifdef AUTO_REPEAT_EN
        rpt_cnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        db_cnt_q[i] <= db_cnt_d[i];
`ifdef AUTO_REPEAT_EN
        rpt_cnt_q[i] <= rpt_cnt_d[i];
`endif
      end
    end
  end

  // Next-state: debounce counter, then FSM deciding step pulses.
  always_comb begin
    stable_d = stable_q;
    pulse_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      db_cnt_d[i] = db_cnt_q[i];
`ifdef AUTO_REPEAT_EN
      rpt_cnt_d[i] = rpt_cnt_q[i];
`endif

      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] < CNT_W'(MAX_TERM)) begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end

      // state_q lags stable_q by one edge, so IDLE with stable high is the rising edge.
      case (state_q[i])
        IDLE: begin
          if (stable_q[i]) begin
            state_d[i] = PRESSED;
            pulse_d[i] = ~other_held[i];
          end
`ifdef AUTO_REPEAT_EN
          rpt_cnt_d[i] = '0;
`endif
        end
        PRESSED: begin
          if (!stable_q[i]) begin
            state_d[i] = IDLE;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_d[i] = '0;
          end else if (other_held[i]) begin
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == CNT_W'(REPEAT_DELAY - 1)) begin
            state_d[i]   = REPEAT;
            pulse_d[i]   = 1'b1;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] < CNT_W'(MAX_TERM)) begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        REPEAT: begin
          if (!stable_q[i]) begin
            state_d[i]   = IDLE;
            rpt_cnt_d[i] = '0;
          end else if (other_held[i]) begin
            state_d[i]   = PRESSED;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == CNT_W'(REPEAT_PERIOD - 1)) begin
            pulse_d[i]   = 1'b1;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] < CNT_W'(MAX_TERM)) begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
          end
        end
`endif
        default: state_d[i] = IDLE;
      endcase
    end
  end

  assign incr_pulse = pulse_q[0];
  assign decr_pulse = pulse_q[1];
  assign incr_held  = stable_q[0];
  assign decr_held  = stable_q[1];

endmodule
